alu_writeback: RTL
==================

Name: alu_writeback

Overview:
- Stage directly downstream of the ALU. Consumes the ALU result, overflow flag and condition flag, and clamps results to the game range of -999..999.
- Holds the architectural accumulator, which is fed back to ALU in0, and the +/- condition-enable state.
- Can also mirror an arithmetic result onto an outgoing XBus port through a req/ack handshake, stalling upstream until the port acknowledges.

Parameters:
- WIDTH, 11, datapath width; matches the ALU.
- SAT_MAX, 999, positive clamp limit; the negative limit is -SAT_MAX.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ALU result present this cycle.
- in_ready  out  1  stage can accept; high only in IDLE.
- funct  in  4  ALU function code for the result: 1000 add, 1001 sub, 1010 mul, 1011 not, 1100 teq, 1101 tgt, 1110 tlt.
- alu_out  in  WIDTH  signed ALU result.
- alu_overflow  in  1  ALU overflow flag.
- alu_cond_flag  in  2  ALU test result: 01 true, 10 false, 00 none.
- op0_sign, op1_sign  in  1 each  sign bits of the ALU operands; used for multiply saturation.
- push  in  1  also send the arithmetic result to the XBus port.
- cond_clear  in  1  clears the condition state; sampled every cycle.
- acc  out  WIDTH  accumulator; fed to ALU in0.
- cond_state  out  2  00 none, 01 '+' lines enabled, 10 '-' lines enabled.
- sat_pulse  out  1  one-cycle pulse when a written result was clamped.
- xbus_data  out  WIDTH  value offered on the XBus port.
- xbus_req  out  1  XBus request.
- xbus_ack  in  1  XBus acknowledge.

Behaviour:
- Reset (async, reset_n=0)
  - acc=0, cond_state=00, sat_pulse=0, xbus_req=0, xbus_data=0, FSM=IDLE.
  - Reset mid-PUSH drops xbus_req immediately and the pending push is lost.
- Accept condition: a beat is accepted on a rising edge when in_valid && in_ready. Inputs are ignored when there is no accept.
- Arithmetic functs (1000, 1001, 1010, 1011), applied on the accept edge:
  - If alu_overflow=0: value = alu_out.
  - If alu_overflow=1 on add or sub: true sign = ~alu_out[WIDTH-1].
  - If alu_overflow=1 on mul: true sign = op0_sign ^ op1_sign.
  - An overflowed value becomes +SAT_MAX or -SAT_MAX according to the true sign.
  - A non-overflowed value > SAT_MAX clamps to SAT_MAX; a value < -SAT_MAX clamps to -SAT_MAX.
  - acc <= clamped value, visible the next cycle (1-cycle latency).
  - sat_pulse is high for exactly the cycle after the accept edge if any clamping occurred.
  - cond_state is unchanged.
- Test functs (1100, 1101, 1110):
  - cond_state <= 01 if alu_cond_flag=01, 10 if alu_cond_flag=10; alu_cond_flag=00 leaves it unchanged.
  - acc is unchanged and push is ignored.
- Any other funct: the beat is accepted and dropped as a bubble; no state changes.
- cond_clear sets cond_state to 00. If it coincides with an accepted test, the test result wins.
- FSM
  - IDLE: in_ready=1. An accepted arithmetic beat with push=1 loads xbus_data with the clamped value and moves to PUSH; otherwise stay in IDLE.
  - PUSH: in_ready=0 and xbus_req=1 (registered, asserted the cycle after accept). xbus_data is held stable. xbus_ack is sampled only while xbus_req=1. On ack the FSM returns to IDLE, so xbus_req falls and in_ready rises on the next cycle.
  - An ack arriving while xbus_req=0 is ignored.
  - acc is already updated in PUSH; the push never delays the writeback.
- Back-to-back: in IDLE, one beat per cycle is sustained with no bubbles.

Test Plan:
- Reset, then add beat alu_out=500, overflow=0 -> acc=500 next cycle, sat_pulse=0, cond_state=00.
- Add beat alu_out=1020 (500+520), overflow=0 -> acc=999, sat_pulse high for 1 cycle; sub beat alu_out=-1010 -> acc=-999.
- Mul beat with overflow=1, op0_sign=1, op1_sign=0 -> acc=-999; same beat with op0_sign=1, op1_sign=1 -> acc=999.
- teq beat alu_cond_flag=01 -> cond_state=01; tgt with 10 and cond_clear in the same cycle -> cond_state=10; cond_clear alone -> 00.
- Add beat with push=1, alu_out=42:
  - xbus_req=1 next cycle, xbus_data=42, in_ready=0, acc=42.
  - Hold xbus_ack=0 for 5 cycles with in_valid=1 -> no accepts.
  - Ack -> req low and in_ready high the next cycle.
- Assert reset_n=0 while in PUSH -> xbus_req=0 and acc=0 immediately; after release, in_ready=1 and cond_state=00.

Source files
------------

// File: rtl/alu_writeback.sv
// Writeback stage behind the ALU: clamps results to +/-SAT_MAX, holds the accumulator
// and +/- condition state, and can mirror an arithmetic result onto the XBus port.
module alu_writeback #(
    parameter int WIDTH   = 11,
    parameter int SAT_MAX = 999
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       funct,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_overflow,
    input  logic [1:0]       alu_cond_flag,
    input  logic             op0_sign,
    input  logic             op1_sign,
    input  logic             push,
    input  logic             cond_clear,
    output logic [WIDTH-1:0] acc,
    output logic [1:0]       cond_state,
    output logic             sat_pulse,
    output logic [WIDTH-1:0] xbus_data,
    output logic             xbus_req,
    input  logic             xbus_ack,
    output logic             fsm_state
);

    localparam logic [3:0] F_ADD = 4'b1000;
    localparam logic [3:0] F_SUB = 4'b1001;
    localparam logic [3:0] F_MUL = 4'b1010;
    localparam logic [3:0] F_NOT = 4'b1011;
    localparam logic [3:0] F_TEQ = 4'b1100;
    localparam logic [3:0] F_TGT = 4'b1101;
    localparam logic [3:0] F_TLT = 4'b1110;

    localparam logic signed [WIDTH-1:0] SAT_POS = WIDTH'(SAT_MAX);
    localparam logic signed [WIDTH-1:0] SAT_NEG = WIDTH'(-SAT_MAX);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PUSH = 1'b1
    } state_t;

    state_t state;

    logic                    accept;
    logic                    is_arith;
    logic                    is_test;
    logic                    ovf_sat;
    logic                    true_neg;
    logic                    clamp_hit;
    logic signed [WIDTH-1:0] value_in;
    logic signed [WIDTH-1:0] clamped;

    // Upstream handshake: a beat transfers on a rising edge where in_valid && in_ready.
    // in_ready is registered and high only in IDLE. The XBus side holds xbus_req and
    // xbus_data stable until xbus_ack is seen with xbus_req high.
    assign accept   = in_valid && in_ready;
    assign is_arith = (funct == F_ADD) || (funct == F_SUB) || (funct == F_MUL) || (funct == F_NOT);
    assign is_test  = (funct == F_TEQ) || (funct == F_TGT) || (funct == F_TLT);
    assign value_in = $signed(alu_out);
    assign fsm_state = state;

    always_comb begin
        ovf_sat   = 1'b0;
        true_neg  = 1'b0;
        clamp_hit = 1'b0;
        clamped   = value_in;
        // An overflowed result's own sign bit is wrong; recover the true sign instead.
        if (alu_overflow && ((funct == F_ADD) || (funct == F_SUB))) begin
            ovf_sat  = 1'b1;
            true_neg = ~alu_out[WIDTH-1];
        end else if (alu_overflow && (funct == F_MUL)) begin
            ovf_sat  = 1'b1;
            true_neg = op0_sign ^ op1_sign;
        end
        if (ovf_sat) begin
            clamp_hit = 1'b1;
            clamped   = true_neg ? SAT_NEG : SAT_POS;
        end else if (value_in > SAT_POS) begin
            clamp_hit = 1'b1;
            clamped   = SAT_POS;
        end else if (value_in < SAT_NEG) begin
            clamp_hit = 1'b1;
            clamped   = SAT_NEG;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc        <= '0;
            cond_state <= 2'b00;
            sat_pulse  <= 1'b0;
        end else begin
            sat_pulse <= accept && is_arith && clamp_hit;
            if (accept && is_arith) begin
                acc <= clamped;
            end
            // An accepted test with a real result overrides a same-cycle clear.
            if (accept && is_test && (alu_cond_flag == 2'b01)) begin
                cond_state <= 2'b01;
            end else if (accept && is_test && (alu_cond_flag == 2'b10)) begin
                cond_state <= 2'b10;
            end else if (cond_clear) begin
                cond_state <= 2'b00;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            xbus_req  <= 1'b0;
            xbus_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && is_arith && push) begin
                        state     <= S_PUSH;
                        in_ready  <= 1'b0;
                        xbus_req  <= 1'b1;
                        xbus_data <= clamped;
                    end
                end
                S_PUSH: begin
                    if (xbus_req && xbus_ack) begin
                        state    <= S_IDLE;
                        in_ready <= 1'b1;
                        xbus_req <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b1;
                    xbus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
